uart_tx: RTL and testbench
==========================

# uart_tx

Asynchronous serial transmitter for the UART path: accepts one data word per valid/ready handshake and shifts it out on `tx` as start bit, data LSB-first, optional parity, and stop bit(s). It is the consumer of the baud tick generator's `tick` output. Each bit lasts exactly OVERSAMPLE ticks. It drives the generator's `enable` input so ticks are produced only while a frame is in flight.

## Interface
- DATA_BITS, 8, data bits per frame (5..9)
- OVERSAMPLE, 4, baud ticks per serial bit (≥1)
- STOP_BITS, 1, stop bits per frame (1 or 2)

- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- tick  in  1  single-cycle baud tick from baud tick generator
- baud_en  out  1  enable to baud tick generator; high while frame in progress
- data  in  DATA_BITS  word to transmit, sampled on handshake
- valid  in  1  upstream has a word
- ready  out  1  block can accept a word (IDLE only)
- tx  out  1  serial line, idle high, registered
- busy  out  1  frame in progress

## Operation
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: ready=1, busy=0, baud_en=0, tx=1, sub-tick counter and bit counter held at 0.
- Handshake = valid && ready at a rising edge. On the handshake, data is captured into the shift register and the state moves to START. Upstream may change `data` afterwards.
- Sub-tick counter: width $clog2(OVERSAMPLE), minimum 1 bit. Increments on each tick. When tick arrives with count == OVERSAMPLE-1, the counter wraps to 0 and the FSM advances one bit.
- START: tx=0 for OVERSAMPLE ticks.
- DATA: tx = shift register bit 0. On each bit advance, shift right and increment the bit counter. After DATA_BITS bits, go to PARITY (if compiled in) or STOP.
- STOP: tx=1 for STOP_BITS×OVERSAMPLE ticks, then go to IDLE.
- tick while baud_en=0 (IDLE) is ignored.
- valid while not ready is ignored. No queuing; the word is not captured.
- Reset asserted mid-frame: immediately (asynchronously) tx=1, state=IDLE, ready=1, busy=0, baud_en=0, counters=0. No partial frame resumes.

## Timing
- Reset values: tx=1, ready=1, busy=0, baud_en=0.
- Handshake at edge N → at edge N: tx=0, busy=1, ready=0, baud_en=1.
- Bit duration is counted only in ticks. Clock cycles between ticks are irrelevant to bit boundaries.
- Each bit boundary is the clock edge that samples the terminal tick. tx changes at that same edge.
- Final stop tick at edge M → at edge M: state=IDLE, ready=1, busy=0, baud_en=0, tx stays 1.
- Back-to-back: valid held high gives a handshake at edge M+1 and the next start bit at M+1. The line idles for a minimum of one clock beyond the stop bit(s).
- Frame length = (1 + DATA_BITS + P + STOP_BITS)×OVERSAMPLE ticks, where P=1 with parity and 0 without.

## Configuration
- UART_TX_PARITY_EN
  - Defined: the PARITY state is compiled in and one even-parity bit follows the data. The bit is the XOR of all captured data bits and lasts OVERSAMPLE ticks.
  - Undefined: the PARITY state and its logic are absent. DATA goes directly to STOP.

## Test plan
- Reset: hold resetn=0 for 3 clk, then release → tx=1, ready=1, busy=0, baud_en=0. No ticks are consumed.
- Single frame (DATA_BITS=8, OVERSAMPLE=4, no parity): send 0xA5 → tx emits 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 ticks. ready returns high at the 40th tick.
- Parity build: send 0xA5 → parity bit 0 (four ones) after the data. Send 0x07 → parity bit 1. Frame is 44 ticks.
- Back-to-back: keep valid=1 with 0x00 then 0xFF → second start bit begins one clk after the first frame's final stop tick. No word is dropped or duplicated.
- Ignored inputs: pulse valid with 0x3C mid-frame → the in-flight frame is unchanged and 0x3C is never transmitted. Pulse tick while idle → tx stays 1.
- Reset mid-frame: assert resetn=0 during the third data bit → tx=1 the same cycle. After release, send 0x55 → a complete, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx -- UART serial transmitter.
//
// Takes one word per valid/ready handshake. It shifts the word out on tx as:
// one start bit, the data LSB first, an optional even-parity bit, and the stop bit(s).
// Every bit lasts OVERSAMPLE baud ticks. baud_en keeps the tick generator running
// only while a frame is in flight.
//
// Optional feature: define UART_TX_PARITY_EN to add one even-parity bit after the
// data. When the macro is undefined the PARITY state and its logic are not built.
//
// Ports:
//   clk      in   system clock, rising edge
//   resetn   in   asynchronous active-low reset
//   tick     in   single-cycle baud tick
//   baud_en  out  tick generator enable, high while a frame is in progress
//   data     in   word to send, captured on the handshake
//   valid    in   upstream has a word
//   ready    out  accepting a word (IDLE only)
//   tx       out  registered serial line, idles high
//   busy     out  frame in progress
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tick,
  output logic                 baud_en,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] SUB_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        sub_q, sub_d;   // ticks within the current bit
  logic [BW-1:0]        bit_q, bit_d;   // data bit index; stop bit index in STOP
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 adv;            // terminal tick of the current bit
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sub_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    adv     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Ticks count only while a frame is in flight. Idle ticks are ignored.
    if (state_q != IDLE && tick) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        adv   = 1'b1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end

    // tx is registered, so each branch loads the level of the *next* bit
    // on the same edge that ends the current one.
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        sub_d = '0;
        bit_d = '0;
        if (valid) begin
          state_d = START;
          sh_d    = data;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      START: if (adv) begin
        state_d = DATA;
        tx_d    = sh_q[0];
      end
      DATA: if (adv) begin
        sh_d = sh_q >> 1;
        if (bit_q == DATA_LAST) begin
          bit_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
          tx_d  = sh_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (adv) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (adv) begin
        if (bit_q == STOP_LAST) begin
          state_d = IDLE;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign ready   = (state_q == IDLE);
  assign busy    = ~ready;
  assign baud_en = ~ready;
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx with DATA_BITS=8, OVERSAMPLE=4,
// and STOP_BITS=1. Each expected frame is a literal bit pattern in the vector
// table, listed LSB first: the start bit, the data, the parity bit (when that
// build is selected), then the stop bit.
module tb_uart_tx;

  localparam int OS = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0]  d;
    logic [10:0] bits;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic       baud_en;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic mid_tx, mid_ready, mid_busy, mid_en;

  vec_t tbl[5];

  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .baud_en(baud_en),
    .data(data), .valid(valid), .ready(ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One tick pulse. The DUT state between the tick edge and the next edge is
  // latched in mid_*. Idle gaps between ticks vary on purpose.
  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    mid_tx = tx; mid_ready = ready; mid_busy = busy; mid_en = baud_en;
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Handshake. Afterwards data is changed to junk to show it was captured.
  task automatic start_frame(input logic [7:0] d, input bit hold);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    chk("hs_tx", tx, 1'b0);
    chk("hs_busy", busy, 1'b1);
    chk("hs_ready", ready, 1'b0);
    chk("hs_baud_en", baud_en, 1'b1);
    if (!hold) begin
      valid = 1'b0;
      data  = 8'h3C;
    end
  endtask

  // Walks every tick of the frame, checking tx before each tick.
  task automatic tick_frame(input logic [10:0] bits, input bit inject);
    for (int b = 0; b < NB; b++) begin
      for (int t = 0; t < OS; t++) begin
        chk("tx_bit", tx, bits[b]);
        if (t == 0) chk("busy_mid", busy, 1'b1);
        if (inject && b == 3 && t == 1) begin
          valid = 1'b1;
          data  = 8'h3C;
          @(negedge clk);
          chk("inject_ready", ready, 1'b0);
          valid = 1'b0;
        end
        if (b == NB - 1 && t == OS - 1) chk("ready_before_last", ready, 1'b0);
        do_tick();
      end
    end
    chk("end_ready", mid_ready, 1'b1);
    chk("end_busy", mid_busy, 1'b0);
    chk("end_baud_en", mid_en, 1'b0);
    chk("end_tx", mid_tx, 1'b1);
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    tbl[0] = '{8'hA5, 11'b1_0_10100101_0};
    tbl[1] = '{8'h07, 11'b1_1_00000111_0};
    tbl[2] = '{8'h00, 11'b1_0_00000000_0};
    tbl[3] = '{8'hFF, 11'b1_0_11111111_0};
    tbl[4] = '{8'h55, 11'b1_0_01010101_0};
`else
    tbl[0] = '{8'hA5, 11'b0_1_10100101_0};
    tbl[1] = '{8'h07, 11'b0_1_00000111_0};
    tbl[2] = '{8'h00, 11'b0_1_00000000_0};
    tbl[3] = '{8'hFF, 11'b0_1_11111111_0};
    tbl[4] = '{8'h55, 11'b0_1_01010101_0};
`endif

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_tx_during", tx, 1'b1);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_baud_en", baud_en, 1'b0);

    // A tick while idle must be ignored
    do_tick();
    chk("idle_tick_tx", tx, 1'b1);
    chk("idle_tick_ready", ready, 1'b1);

    // Table-driven frames. Vector 1 also gets a valid pulse mid-frame.
    for (int i = 0; i < 5; i++) begin
      start_frame(tbl[i].d, 1'b0);
      tick_frame(tbl[i].bits, i == 1);
      repeat (3) @(negedge clk);
      chk("idle_after_ready", ready, 1'b1);
      chk("idle_after_tx", tx, 1'b1);
    end

    // Back-to-back: valid held high, first 0x00 and then 0xFF
    start_frame(tbl[2].d, 1'b1);
    data = tbl[3].d;
    tick_frame(tbl[2].bits, 1'b0);
    valid = 1'b0;
    data  = 8'h3C;
    chk("b2b_restart_tx", tx, 1'b0);
    chk("b2b_restart_busy", busy, 1'b1);
    tick_frame(tbl[3].bits, 1'b0);
    repeat (3) @(negedge clk);
    chk("b2b_no_dup", busy, 1'b0);

    // Reset during the third data bit (frame bit index 3)
    start_frame(tbl[0].d, 1'b0);
    repeat (3 * OS + 1) do_tick();
    chk("pre_rst_busy", busy, 1'b1);
    resetn = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_ready", ready, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_baud_en", baud_en, 1'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    start_frame(tbl[4].d, 1'b0);
    tick_frame(tbl[4].bits, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
